dct8_cordic_rot: RTL and testbench

- Pipelined fixed-angle CORDIC rotator that serves as the rotation block behind dct8_rearrange in the memory-based DCT-8.
- Consumes the (rot_x_in, rot_y_in) pair and returns the rotated pair (rot_x_out, rot_y_out), which is written back to memory.
- The rotation angle is one of four DCT-8 butterfly angles, selected per sample.
- Gain is compensated internally, so output magnitude equals input magnitude.

---
 rtl/dct8_cordic_rot_pkg.sv | 46 ++++
 rtl/dct8_cordic_stage.sv | 78 +++++++
 rtl/dct8_cordic_rot.sv | 155 +++++++++++++++
 tb/tb_dct8_cordic_rot.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dct8_cordic_rot_pkg.sv
// rtl/dct8_cordic_rot_pkg.sv - shared constants, angle encodings and sigma lookup for the DCT-8 CORDIC rotator
//
// Purpose: single home for the DCT-8 rotator constants. Holds the sample width,
// the gain-compensation multiplier and the four precomputed sigma vectors.
// Ports: none (package).
//
// Each sigma vector was produced offline by greedy angle reduction:
// z0 = theta, sigma_i = (z_i >= 0), z_{i+1} = z_i -/+ atan(2^-i).
// Bit i of a vector drives micro-rotation stage i.

package dct8_cordic_rot_pkg;

    localparam int DCT8_IN_W      = 16;
    localparam int DCT8_CORDIC_KQ = 19898;   // round(0.6072529 * 2^15)
    localparam int DCT8_KQ_SHIFT  = 15;

    // Headroom above the sample MSB. The CORDIC gain (~1.647) applied to a
    // diagonal full-scale input (|v| ~ sqrt(2) * 2^15) needs more than one
    // growth bit, so two are carried to keep the datapath from wrapping.
    localparam int DCT8_HEAD_W    = 2;

    localparam logic [15:0] DCT8_SIG_PI4   = 16'hAF83;
    localparam logic [15:0] DCT8_SIG_PI16  = 16'h0DE9;
    localparam logic [15:0] DCT8_SIG_3PI16 = 16'h6E8D;
    localparam logic [15:0] DCT8_SIG_3PI8  = 16'hF4DB;

    typedef enum logic [1:0] {
        DCT8_ANG_PI4   = 2'd0,
        DCT8_ANG_PI16  = 2'd1,
        DCT8_ANG_3PI16 = 2'd2,
        DCT8_ANG_3PI8  = 2'd3
    } dct8_angle_e;

    // Rotation direction for stage idx under angle sel (1 = counter-clockwise).
    function automatic logic dct8_sigma(input logic [1:0] sel, input logic [3:0] idx);
        logic s;
        case (sel)
            DCT8_ANG_PI4:   s = DCT8_SIG_PI4[idx];
            DCT8_ANG_PI16:  s = DCT8_SIG_PI16[idx];
            DCT8_ANG_3PI16: s = DCT8_SIG_3PI16[idx];
            default:        s = DCT8_SIG_3PI8[idx];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dct8_cordic_stage.sv
// rtl/dct8_cordic_stage.sv - one registered CORDIC micro-rotation stage
//
// Purpose: applies x' = x -/+ (y >>> SHIFT), y' = y +/- (x >>> SHIFT) with the
// direction taken from the sigma table for the sample's angle, and forwards the
// valid bit and angle_sel alongside the data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_angle    incoming valid bit and angle select
//   in_x, in_y            incoming signed W-bit datapath values
//   out_valid, out_angle  registered valid bit and angle select
//   out_x, out_y          registered rotated values (held while idle)

module dct8_cordic_stage
    import dct8_cordic_rot_pkg::*;
#(
    parameter int W     = 21,
    parameter int SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [1:0]          in_angle,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    output logic                out_valid,
    output logic [1:0]          out_angle,
    output logic signed [W-1:0] out_x,
    output logic signed [W-1:0] out_y
);

    logic                valid_q, valid_d;
    logic [1:0]          angle_q, angle_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic                sigma;
    logic signed [W-1:0] x_sh, y_sh;

    always_comb begin
        sigma   = dct8_sigma(in_angle, 4'(SHIFT));
        x_sh    = in_x >>> SHIFT;
        y_sh    = in_y >>> SHIFT;
        valid_d = in_valid;
        angle_d = angle_q;
        x_d     = x_q;
        y_d     = y_q;
        // Data only advances with a valid sample so idle slots keep the last result.
        if (in_valid) begin
            angle_d = in_angle;
            if (sigma) begin
                x_d = in_x - y_sh;
                y_d = in_y + x_sh;
            end else begin
                x_d = in_x + y_sh;
                y_d = in_y - x_sh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            angle_q <= angle_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign out_valid = valid_q;
    assign out_angle = angle_q;
    assign out_x     = x_q;
    assign out_y     = y_q;

endmodule

// File: rtl/dct8_cordic_rot.sv
// rtl/dct8_cordic_rot.sv - pipelined fixed-angle CORDIC rotator for the memory-based DCT-8
//
// Purpose: rotates (x_in, y_in) counter-clockwise by one of four DCT-8
// butterfly angles with the CORDIC gain removed, one sample per cycle,
// latency ITER+2 cycles, saturating outputs.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       input sample valid
//   angle_sel      0=pi/4, 1=pi/16, 2=3pi/16, 3=3pi/8
//   x_in, y_in     signed DATA_W-bit input pair
//   out_valid      x_out/y_out carry a new result this cycle
//   x_out, y_out   signed DATA_W-bit rotated pair (held while out_valid=0)

module dct8_cordic_rot
    import dct8_cordic_rot_pkg::*;
#(
    parameter int DATA_W = DCT8_IN_W,
    parameter int ITER   = 16,
    parameter int GUARD  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [1:0]               angle_sel,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] x_out,
    output logic signed [DATA_W-1:0] y_out
);

    localparam int W  = DATA_W + DCT8_HEAD_W + GUARD;
    localparam int PW = W + 18;
    localparam int SH = DCT8_KQ_SHIFT + GUARD;

    localparam logic signed [PW-1:0] KQ_P = PW'(DCT8_CORDIC_KQ);
    localparam logic signed [PW-1:0] RND  = PW'(64'sd1 <<< (SH - 1));
    localparam logic signed [PW-1:0] SMAX = PW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    // Stage 0: input capture with sign extension and guard bits.
    logic                s0_valid_q, s0_valid_d;
    logic [1:0]          s0_angle_q, s0_angle_d;
    logic signed [W-1:0] s0_x_q, s0_x_d;
    logic signed [W-1:0] s0_y_q, s0_y_d;

    always_comb begin
        s0_valid_d = in_valid;
        s0_angle_d = s0_angle_q;
        s0_x_d     = s0_x_q;
        s0_y_d     = s0_y_q;
        if (in_valid) begin
            s0_angle_d = angle_sel;
            s0_x_d     = {{DCT8_HEAD_W{x_in[DATA_W-1]}}, x_in, {GUARD{1'b0}}};
            s0_y_d     = {{DCT8_HEAD_W{y_in[DATA_W-1]}}, y_in, {GUARD{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_angle_q <= '0;
            s0_x_q     <= '0;
            s0_y_q     <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_angle_q <= s0_angle_d;
            s0_x_q     <= s0_x_d;
            s0_y_q     <= s0_y_d;
        end
    end

    // Micro-rotation chain; index k is the output of stage k-1 (0 = capture stage).
    logic [ITER:0]              vld;
    logic [ITER:0][1:0]         ang;
    logic [ITER:0][W-1:0]       xs;
    logic [ITER:0][W-1:0]       ys;
    logic [1:0]                 ang_unused;

    assign vld[0] = s0_valid_q;
    assign ang[0] = s0_angle_q;
    assign xs[0]  = s0_x_q;
    assign ys[0]  = s0_y_q;

    // The angle is no longer needed once the last micro-rotation is done.
    assign ang_unused = ang[ITER];

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        dct8_cordic_stage #(
            .W     (W),
            .SHIFT (i)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[i]),
            .in_angle  (ang[i]),
            .in_x      (xs[i]),
            .in_y      (ys[i]),
            .out_valid (vld[i+1]),
            .out_angle (ang[i+1]),
            .out_x     (xs[i+1]),
            .out_y     (ys[i+1])
        );
    end

    // Gain stage: multiply by K, round half-up, drop guard and K fraction, clamp.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > SMAX) begin
            r = SMAX[DATA_W-1:0];
        end else if (v < SMIN) begin
            r = SMIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    logic signed [PW-1:0]     prod_x, prod_y;
    logic signed [PW-1:0]     rnd_x, rnd_y;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] x_out_q, x_out_d;
    logic signed [DATA_W-1:0] y_out_q, y_out_d;

    always_comb begin
        prod_x      = PW'($signed(xs[ITER])) * KQ_P;
        prod_y      = PW'($signed(ys[ITER])) * KQ_P;
        rnd_x       = (prod_x + RND) >>> SH;
        rnd_y       = (prod_y + RND) >>> SH;
        out_valid_d = vld[ITER];
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        if (vld[ITER]) begin
            x_out_d = sat(rnd_x);
            y_out_d = sat(rnd_y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;

endmodule

// File: tb/tb_dct8_cordic_rot.sv
// tb/tb_dct8_cordic_rot.sv - scoreboard bench for dct8_cordic_rot against a real-valued rotation model

module tb_dct8_cordic_rot;

    localparam int  LAT = 18;
    localparam int  TOL = 2;
    localparam real PI  = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [1:0]         angle_sel;
    logic signed [15:0] x_in, y_in;
    logic               out_valid;
    logic signed [15:0] x_out, y_out;

    dct8_cordic_rot dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .angle_sel (angle_sel),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ex;
        int ey;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hold_x   = 0;
    int   hold_y   = 0;

    function automatic real theta(input logic [1:0] a);
        case (a)
            2'd0:    return PI / 4.0;
            2'd1:    return PI / 16.0;
            2'd2:    return 3.0 * PI / 16.0;
            default: return 3.0 * PI / 8.0;
        endcase
    endfunction

    // Ideal rounded result, clamped to the signed 16-bit range.
    function automatic int ideal(input real v);
        real r;
        r = (v >= 0.0) ? $floor(v + 0.5) : $ceil(v - 0.5);
        if (r > 32767.0) r = 32767.0;
        if (r < -32768.0) r = -32768.0;
        return $rtoi(r);
    endfunction

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if ((act - exp <= tol) && (exp - act <= tol)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic send(input bit v, input logic [1:0] a, input int x, input int y);
        exp_t e;
        real  th;
        @(posedge clk);
        #1;
        in_valid  = v;
        angle_sel = a;
        x_in      = 16'(x);
        y_in      = 16'(y);
        if (v) begin
            th    = theta(a);
            e.cyc = cyc + LAT;
            e.ex  = ideal(real'(x) * $cos(th) - real'(y) * $sin(th));
            e.ey  = ideal(real'(x) * $sin(th) + real'(y) * $cos(th));
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 2'd0, 0, 0);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(32768)) - 16384;
    endfunction

    // Monitor: compares every presented result with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_x = 0;
            hold_y = 0;
            check("reset_out_valid", int'(out_valid), 0, 0);
            check("reset_x_out", int'(x_out), 0, 0);
            check("reset_y_out", int'(y_out), 0, 0);
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", int'(out_valid), 0, 0);
            end else begin
                e = sb.pop_front();
                check("latency_cycle", cyc, e.cyc, 0);
                check("x_out", int'(x_out), e.ex, TOL);
                check("y_out", int'(y_out), e.ey, TOL);
                hold_x = e.ex;
                hold_y = e.ey;
            end
        end else begin
            check("hold_x_out", int'(x_out), hold_x, TOL);
            check("hold_y_out", int'(y_out), hold_y, TOL);
        end
    end

    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        angle_sel = 2'd0;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single pulse: latency and no extra pulses.
        send(1'b1, 2'd0, 1000, 0);
        idle(24);

        // Back-to-back over all four angles.
        for (int a = 0; a < 4; a++) send(1'b1, 2'(a), 10000, 0);
        idle(20);

        // Bubbles in in_valid must reappear unchanged at the output.
        for (int i = 0; i < 6; i++) send(pat[i], 2'($urandom_range(3)), rnd_sample(), rnd_sample());
        idle(20);

        // Saturation at both extremes.
        send(1'b1, 2'd0, 32767, 32767);
        send(1'b1, 2'd0, -32768, -32768);
        idle(20);

        // Reset while five samples are in flight.
        for (int i = 0; i < 5; i++) send(1'b1, 2'($urandom_range(3)), rnd_sample(), rnd_sample());
        idle(2);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #2;
        check("midflight_reset_valid", int'(out_valid), 0, 0);
        check("midflight_reset_x", int'(x_out), 0, 0);
        check("midflight_reset_y", int'(y_out), 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(25);

        // Random stream with occasional gaps.
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(9) == 0) send(1'b0, 2'd0, 0, 0);
            send(1'b1, 2'($urandom_range(3)), rnd_sample(), rnd_sample());
        end
        idle(25);

        check("scoreboard_drained", sb.size(), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
